mem_stage_ls: RTL and testbench
===============================

Name: mem_stage_ls

Overview:
- Parametrised successor of the pipeline memory stage.
- Adds sub-word loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) with byte-lane enables and sign/zero extension.
- Adds a configurable-latency memory access driven by a small FSM, with a Stall handshake back to the pipeline.
- Sits between EX and WB. The selected result (load data or ALUResult) drives WB.

Parameters:
- ADDR_W, 14, word-address width; memory depth = 2**ADDR_W 32-bit words.
- LATENCY, 1, extra wait cycles per access (0..15); BUSY lasts LATENCY+1 cycles.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- MemRead  input  1  load request.
- MemWrite  input  1  store request; wins if MemRead is also high.
- MemtoReg  input  1  1 = DataOut is load data; 0 = DataOut is ALUResult.
- Funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are treated as W.
- ALUResult  input  32  byte address, or the pass-through result.
- DataIn  input  32  store data; the low byte or half is used for SB/SH.
- DataOut  output  32  write-back value.
- Stall  output  1  1 = pipeline must hold all inputs stable and not advance.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, wait counter=0, load register=0, DataOut=0, Stall=0. Memory array is not cleared.
- States:
  - IDLE: no access in progress.
  - BUSY: memory access under way, counter running.
  - DONE: load data valid for one cycle.
- IDLE:
  - req = MemRead|MemWrite.
  - req=0 -> Stall=0; DataOut = MemtoReg ? 0 : ALUResult, combinationally.
  - req=1 -> Stall=1 combinationally; latch address/Funct3/DataIn/op; counter<=LATENCY; next state BUSY.
- BUSY:
  - Stall=1; synchronous RAM address = latched ALUResult[ADDR_W+1:2]; upper address bits ignored, so addresses wrap.
  - counter>0 -> decrement.
  - counter==0 -> store: commit the byte-enabled write at this edge. Load: capture the extended read data into the load register. Next state DONE.
- DONE:
  - Stall=0; DataOut = MemtoReg ? load register : latched ALUResult. The pipeline advances at this edge.
  - Next state IDLE; a new request is sampled in the following cycle.
- Latency: Stall is high for exactly LATENCY+2 cycles per memory op. Non-memory ops never stall.
- Byte lanes:
  - SB writes lane ALUResult[1:0].
  - SH writes lanes {1,0} if ALUResult[1]=0, else {3,2}.
  - SW writes all four lanes.
- Load extension:
  - LB/LH sign-extend bit 7/15 of the selected lane.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- Alignment (macro undefined): H ignores ALUResult[0]; W ignores ALUResult[1:0].
- Simultaneous MemRead and MemWrite: performed as a store only; DataOut in DONE is the latched ALUResult if MemtoReg=0, else 0.
- Reset mid-operation: state returns to IDLE. A store not yet committed (edge not reached) is dropped; a committed store persists.
- Input changes while Stall=1 are ignored, because the operation runs on latched values.

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined:
  - Adds output MisalignErr (1 bit).
  - In IDLE, a request with H and ALUResult[0]=1, or W and ALUResult[1:0]!=0, raises MisalignErr=1 combinationally.
  - That request is not started: Stall=0, no memory write, DataOut=0.
  - MisalignErr is reset to 0 and is 0 otherwise.
- Undefined: port absent; addresses are force-aligned as above.

Decomposition:
- Shared package mem_ls_pkg:
  - Funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state encoding: ST_IDLE, ST_BUSY, ST_DONE.
  - Lane-enable and extension helper functions.
- One sub-module: mem_bank_be. Synchronous-read, 4-bit byte-write-enable RAM, depth 2**ADDR_W, no reset on the array.

Test Plan:
- LATENCY=1; SW 0xDEADBEEF @0x10, then LW @0x10 with MemtoReg=1 -> Stall high 3 cycles each; DataOut=0xDEADBEEF in DONE.
- After the above: LB @0x11 -> 0xFFFFFFBE; LBU @0x11 -> 0x000000BE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
- SB 0x12 @0x13, then LW @0x10 -> 0x12ADBEEF; SH 0x3456 @0x10, then LW -> 0x12AD3456.
- MemRead=MemWrite=0, ALUResult=0x55 -> DataOut=0x55 the same cycle, Stall=0; MemRead=MemWrite=1 -> write performed, no load.
- rst pulsed low during BUSY of SW 0x1 @0x20 before commit -> Stall=0 and DataOut=0 immediately; a later LW @0x20 returns the old value.
- MEM_MISALIGN_TRAP_EN defined: LW @0x22 -> MisalignErr=1, Stall=0, DataOut=0; SH @0x21 -> no write, memory unchanged.

Source files
------------

// File: rtl/mem_ls_pkg.sv
// Shared types and helpers for the load/store memory stage: Funct3 codes,
// FSM encoding, latched request record, byte-lane and extension functions.
package mem_ls_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic        is_store;
        logic        is_load;
        logic        mtr;
    } req_t;

    // Undefined Funct3 codes fall through to a full word access.
    function automatic size_t f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            default:     return SZ_W;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3_size(f3))
            SZ_B:    return 4'b0001 << off;
            SZ_H:    return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicating the narrow datum across lanes lets the byte enables pick the slot.
    function automatic logic [31:0] store_rep(input logic [31:0] d, input logic [2:0] f3);
        case (f3_size(f3))
            SZ_B:    return {4{d[7:0]}};
            SZ_H:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            F3_B:    return {{24{b[7]}}, b};
            F3_BU:   return {24'h0, b};
            F3_H:    return {{16{h[15]}}, h};
            F3_HU:   return {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3_size(f3))
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_bank_be.sv
// Synchronous-read word RAM with per-byte write enables; array is never reset.
module mem_bank_be #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        be,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_q;

        always_ff @(posedge clk) begin
            if (be[l]) mem[addr] <= wdata[8*l +: 8];
            rd_q <= mem[addr];
        end

        assign rdata[8*l +: 8] = rd_q;
    end

endmodule

// File: rtl/mem_stage_ls.sv
// Pipeline memory stage with sub-word loads/stores and a fixed-latency access FSM.
// Define MEM_MISALIGN_TRAP_EN to reject misaligned H/W accesses via MisalignErr.
module mem_stage_ls
    import mem_ls_pkg::*;
#(
    parameter int ADDR_W  = 14,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemtoReg,
    input  logic [2:0]  Funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        Stall
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        MisalignErr
`endif
);
    localparam logic [3:0] LAT = 4'(LATENCY);

    state_t            state, state_nxt;
    req_t              lat, req_now;
    logic [3:0]        cnt;
    logic [31:0]       load_q, rdata, wdata;
    logic [3:0]        be;
    logic [ADDR_W-1:0] ram_addr;
    logic              req, misalign, start, commit;

    assign req = MemRead | MemWrite;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign    = req && is_misaligned(Funct3, ALUResult[1:0]);
    assign MisalignErr = rst && (state == ST_IDLE) && misalign;
`else
    assign misalign = 1'b0;
`endif

    assign start  = (state == ST_IDLE) && req && !misalign;
    assign commit = (state == ST_BUSY) && (cnt == 4'd0);

    // A simultaneous read+write is carried out as a store only.
    assign req_now = '{addr:     ALUResult,
                       wdata:    DataIn,
                       f3:       Funct3,
                       is_store: MemWrite,
                       is_load:  MemRead & ~MemWrite,
                       mtr:      MemtoReg};

    // Presenting the live address while idle lets the first BUSY cycle already see read data.
    assign ram_addr = (state == ST_IDLE) ? ALUResult[ADDR_W+1:2] : lat.addr[ADDR_W+1:2];
    assign be       = (commit && lat.is_store) ? lane_be(lat.f3, lat.addr[1:0]) : 4'b0000;
    assign wdata    = store_rep(lat.wdata, lat.f3);

    mem_bank_be #(.ADDR_W(ADDR_W)) u_bank (
        .clk   (clk),
        .addr  (ram_addr),
        .be    (be),
        .wdata (wdata),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            cnt    <= 4'd0;
            load_q <= 32'd0;
            lat    <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                lat <= req_now;
                cnt <= LAT;
            end else if (state == ST_BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit && lat.is_load) load_q <= load_ext(rdata, lat.f3, lat.addr[1:0]);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_BUSY;
            ST_BUSY: if (cnt == 4'd0) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        Stall   = 1'b0;
        DataOut = 32'd0;
        case (state)
            ST_IDLE: begin
                if (start)                 Stall   = 1'b1;
                else if (!req && !MemtoReg) DataOut = ALUResult;
            end
            ST_BUSY: Stall = 1'b1;
            ST_DONE: begin
                if (!lat.mtr)          DataOut = lat.addr;
                else if (lat.is_load)  DataOut = load_q;
            end
            default: ;
        endcase
        // Outputs read as their reset values for as long as reset is held.
        if (!rst) begin
            Stall   = 1'b0;
            DataOut = 32'd0;
        end
    end

endmodule

// File: tb/tb_mem_stage_ls.sv
// Self-checking bench for mem_stage_ls: directed vector table, reset corner
// sequences, and randomized ops checked against a byte-array reference model.
module tb_mem_stage_ls;
    localparam int LAT = 1;
    localparam int AW  = 14;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite, MemtoReg;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult, DataIn, DataOut;
    logic        Stall;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic        rd, wr, mtr;
        logic [2:0]  f3;
        logic [31:0] addr, din, exp_out;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] ref_mem [256];

    mem_stage_ls #(.ADDR_W(AW), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .MemtoReg  (MemtoReg),
        .Funct3    (Funct3),
        .ALUResult (ALUResult),
        .DataIn    (DataIn),
        .DataOut   (DataOut),
        .Stall     (Stall)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .MisalignErr (misalign_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic rd, input logic wr, input logic mtr,
                           input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] din,
                           input logic [31:0] exp_out);
        vec_t v;
        v = '{name, rd, wr, mtr, f3, addr, din, exp_out};
        vecs.push_back(v);
    endtask

    // Issue one op and wait for Stall to drop; inputs are scrambled while
    // stalled since the op must run on its captured values.
    task automatic do_op(input logic rd, input logic wr, input logic mtr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] din,
                         output logic [31:0] dout, output int stalls);
        bit done;
        done = 0;
        @(negedge clk);
        MemRead = rd; MemWrite = wr; MemtoReg = mtr; Funct3 = f3; ALUResult = addr; DataIn = din;
        stalls = 0;
        dout   = 32'hxxxxxxxx;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (Stall) begin
                stalls++;
                @(negedge clk);
                ALUResult = $urandom;
                DataIn    = $urandom;
                Funct3    = 3'($urandom);
                MemtoReg  = 1'($urandom);
            end else begin
                dout = DataOut;
                done = 1;
            end
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL timeout: Stall still 1 after 40 cycles, expected 0");
        end
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    function automatic int ref_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
        int          n, base;
        logic [31:0] v;
        n    = ref_size(f3);
        base = int'(addr[7:0]) & ~(n - 1);
        v    = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
        if (f3 == 3'd0) v = 32'($signed(v[7:0]));
        if (f3 == 3'd1) v = 32'($signed(v[15:0]));
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] din);
        int n, base;
        n    = ref_size(f3);
        base = int'(addr[7:0]) & ~(n - 1);
        for (int i = 0; i < n; i++) ref_mem[base + i] = din[8*i +: 8];
    endtask

    initial begin
        logic [31:0] dout;
        int          st;

        // Reset: outputs forced quiet even with a request on the inputs.
        rst = 1'b0; MemRead = 1'b1; MemWrite = 1'b0; MemtoReg = 1'b0;
        Funct3 = 3'd2; ALUResult = 32'h55; DataIn = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        check("reset Stall", 32'(Stall), 32'd0);
        check("reset DataOut", DataOut, 32'd0);
        @(negedge clk);
        MemRead = 1'b0;
        rst = 1'b1;

        add_vec("SW deadbeef",    0, 1, 0, 3'd2, 32'h10,    32'hDEADBEEF, 32'h10);
        add_vec("LW 10",          1, 0, 1, 3'd2, 32'h10,    32'h0,        32'hDEADBEEF);
        add_vec("LB 11",          1, 0, 1, 3'd0, 32'h11,    32'h0,        32'hFFFFFFBE);
        add_vec("LBU 11",         1, 0, 1, 3'd4, 32'h11,    32'h0,        32'h000000BE);
        add_vec("LH 12",          1, 0, 1, 3'd1, 32'h12,    32'h0,        32'hFFFFDEAD);
        add_vec("LHU 10",         1, 0, 1, 3'd5, 32'h10,    32'h0,        32'h0000BEEF);
        add_vec("SB 13",          0, 1, 0, 3'd0, 32'h13,    32'hAAAAAA12, 32'h13);
        add_vec("LW after SB",    1, 0, 1, 3'd2, 32'h10,    32'h0,        32'h12ADBEEF);
        add_vec("SH 10",          0, 1, 0, 3'd1, 32'h10,    32'hFFFF3456, 32'h10);
        add_vec("LW after SH",    1, 0, 1, 3'd2, 32'h10,    32'h0,        32'h12AD3456);
        add_vec("nop pass",       0, 0, 0, 3'd2, 32'h55,    32'h0,        32'h55);
        add_vec("nop mtr",        0, 0, 1, 3'd2, 32'h55,    32'h0,        32'h0);
        add_vec("RW mtr1",        1, 1, 1, 3'd2, 32'h14,    32'hCAFEF00D, 32'h0);
        add_vec("LW 14",          1, 0, 1, 3'd2, 32'h14,    32'h0,        32'hCAFEF00D);
        add_vec("RW mtr0",        1, 1, 0, 3'd2, 32'h18,    32'h11223344, 32'h18);
        add_vec("LH 13 aligned",  1, 0, 1, 3'd1, 32'h13,    32'h0,        32'h000012AD);
        add_vec("LW 12 aligned",  1, 0, 1, 3'd2, 32'h12,    32'h0,        32'h12AD3456);
        add_vec("SH 17 upper",    0, 1, 0, 3'd1, 32'h17,    32'h0000BEEF, 32'h17);
        add_vec("LW 14 lanes",    1, 0, 1, 3'd2, 32'h14,    32'h0,        32'hBEEFF00D);
        add_vec("S f3=3 as W",    0, 1, 0, 3'd3, 32'h19,    32'hA5A5A5A5, 32'h19);
        add_vec("L f3=7 as W",    1, 0, 1, 3'd7, 32'h18,    32'h0,        32'hA5A5A5A5);
        add_vec("LW wrap",        1, 0, 1, 3'd2, 32'h10010, 32'h0,        32'h12AD3456);

        foreach (vecs[i]) begin
            do_op(vecs[i].rd, vecs[i].wr, vecs[i].mtr, vecs[i].f3, vecs[i].addr, vecs[i].din, dout, st);
            check({vecs[i].name, " out"}, dout, vecs[i].exp_out);
            check({vecs[i].name, " stall"}, 32'(st),
                  (vecs[i].rd || vecs[i].wr) ? 32'(LAT + 2) : 32'd0);
        end

        // Reset before the commit edge drops the store.
        do_op(0, 1, 0, 3'd2, 32'h20, 32'h0BADF00D, dout, st);
        @(negedge clk);
        MemWrite = 1'b1; MemRead = 1'b0; MemtoReg = 1'b0; Funct3 = 3'd2; ALUResult = 32'h20; DataIn = 32'h1;
        @(negedge clk);
        #1;
        check("pre-reset busy Stall", 32'(Stall), 32'd1);
        rst = 1'b0;
        #1;
        check("mid reset Stall", 32'(Stall), 32'd0);
        check("mid reset DataOut", DataOut, 32'd0);
        MemWrite = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        do_op(1, 0, 1, 3'd2, 32'h20, 32'h0, dout, st);
        check("dropped store", dout, 32'h0BADF00D);

        // Reset after the commit edge keeps the store.
        @(negedge clk);
        MemWrite = 1'b1; MemtoReg = 1'b0; Funct3 = 3'd2; ALUResult = 32'h24; DataIn = 32'h2;
        repeat (LAT + 2) @(negedge clk);
        #1;
        check("done Stall", 32'(Stall), 32'd0);
        MemWrite = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        do_op(1, 0, 1, 3'd2, 32'h24, 32'h0, dout, st);
        check("committed store", dout, 32'h2);

        // Seed the model region, then randomized traffic.
        for (int w = 0; w < 64; w++) begin
            logic [31:0] d;
            d = $urandom;
            do_op(0, 1, 0, 3'd2, 32'(w * 4), d, dout, st);
            ref_store(3'd2, 32'(w * 4), d);
        end
        for (int k = 0; k < 300; k++) begin
            int          kind;
            logic        rd, wr, mtr;
            logic [2:0]  f3;
            logic [31:0] addr, din, exp;
            kind = $urandom_range(0, 3);
            rd   = (kind == 1) || (kind == 3);
            wr   = (kind >= 2);
            mtr  = 1'($urandom);
            f3   = 3'($urandom);
            addr = ($urandom & 32'hFFFF0000) | 32'($urandom_range(0, 255));
            din  = $urandom;
            exp  = mtr ? ((rd && !wr) ? ref_load(f3, addr) : 32'd0) : addr;
            if (wr) ref_store(f3, addr, din);
            do_op(rd, wr, mtr, f3, addr, din, dout, st);
            check($sformatf("rnd%0d out", k), dout, exp);
            check($sformatf("rnd%0d stall", k), 32'(st), (rd || wr) ? 32'(LAT + 2) : 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
